// File: rtl/board_io_pkg.sv
// Shared constants, types and parameter legality check for the CPU <-> board pin bridge.
package board_io_pkg;

  localparam int MAX_CHANNELS  = 8;
  localparam int BOARD_CLK_DIV = 2;
  localparam int PORT_WIDTH    = 16;

  typedef logic [PORT_WIDTH-1:0] port_word_t;

  // sts_data carries one flag per channel, so the port word must be at least CHANNELS wide.
  function automatic bit params_legal(int channels, int width, int clk_div, int debounce);
    return (channels >= 1) && (channels <= MAX_CHANNELS) && (width >= channels) &&
           (clk_div >= 1) && (debounce >= 1);
  endfunction

endpackage

// File: rtl/board_io_bridge_sw_debounce.sv
// One switch channel: 2-FF synchroniser, whole-vector debounce, and a pulse when the accepted value changes.
module sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             changed_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q, cand_q, stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             settled;

  // stable_q is reloaded every settled cycle; only a real difference counts as a change.
  assign settled   = (sync_q == cand_q) && (cnt_q == CNT_LAST);
  assign changed_o = settled && (cand_q != stable_q);
  assign stable_o  = stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
      if (sync_q != cand_q) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_io_bridge.sv
// Bridge between CPU port bus and board switches/LEDs: clock-enable divider, debounced inputs,
// cpu_ce-qualified LED latches and per-channel sticky change flags.
module board_io_bridge
  import board_io_pkg::*;
#(
  parameter int               CHANNELS        = 1,
  parameter int               WIDTH           = 16,
  parameter int               CLK_DIV         = BOARD_CLK_DIV,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] LED_RESET       = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      cpu_ce,
  input  logic [CHANNELS*WIDTH-1:0] sw_in,
  output logic [CHANNELS*WIDTH-1:0] led_out,
  output logic [CHANNELS*WIDTH-1:0] cpu_rd_data,
  input  logic [CHANNELS*WIDTH-1:0] cpu_wr_data,
  input  logic [CHANNELS-1:0]       cpu_wr_strobe,
  input  logic [CHANNELS-1:0]       cpu_rd_strobe,
  output logic [WIDTH-1:0]          sts_data
);

  if (!params_legal(CHANNELS, WIDTH, CLK_DIV, DEBOUNCE_CYCLES)) begin : g_bad_params
    $error("board_io_bridge: illegal parameter set");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]          div_q, div_d;
  logic                      ce_q;
  logic [CHANNELS*WIDTH-1:0] led_q, led_d;
  logic [CHANNELS-1:0]       changed, flag_q, flag_d;
  logic [WIDTH-1:0]          sts_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sw_debounce #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_i     (sw_in[c*WIDTH +: WIDTH]),
      .stable_o (cpu_rd_data[c*WIDTH +: WIDTH]),
      .changed_o(changed[c])
    );
  end

  // CPU strobes only count in the cycle where the registered cpu_ce is high.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    led_d = led_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cpu_wr_strobe[c] && ce_q) begin
        led_d[c*WIDTH +: WIDTH] = cpu_wr_data[c*WIDTH +: WIDTH];
      end
    end
    // A new change wins over a read clear landing in the same cycle.
    flag_d = changed | (flag_q & ~(cpu_rd_strobe & {CHANNELS{ce_q}}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      ce_q   <= 1'b0;
      led_q  <= {CHANNELS{LED_RESET}};
      flag_q <= '0;
      sts_q  <= '0;
    end else begin
      div_q  <= div_d;
      ce_q   <= (div_q == DIV_LAST);
      led_q  <= led_d;
      flag_q <= flag_d;
      sts_q  <= WIDTH'(flag_q);
    end
  end

  assign cpu_ce   = ce_q;
  assign led_out  = led_q;
  assign sts_data = sts_q;

endmodule

// File: tb/tb_board_io_bridge.sv
// Directed bench for board_io_bridge: 2 channels, CLK_DIV=4, DEBOUNCE_CYCLES=4.
module tb_board_io_bridge;

  localparam int          CH   = 2;
  localparam int          W    = 16;
  localparam logic [15:0] LEDR = 16'h5A3C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_ce;
  logic [31:0]   sw_in, led_out, cpu_rd_data, cpu_wr_data;
  logic [1:0]    cpu_wr_strobe, cpu_rd_strobe;
  logic [15:0]   sts_data;

  int n_cmp  = 0;
  int n_fail = 0;

  board_io_bridge #(
    .CHANNELS(CH), .WIDTH(W), .CLK_DIV(4), .DEBOUNCE_CYCLES(4), .LED_RESET(LEDR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_ce(cpu_ce), .sw_in(sw_in), .led_out(led_out),
    .cpu_rd_data(cpu_rd_data), .cpu_wr_data(cpu_wr_data), .cpu_wr_strobe(cpu_wr_strobe),
    .cpu_rd_strobe(cpu_rd_strobe), .sts_data(sts_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0]  wr;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        on_ce;
    logic [15:0] e0;
    logic [15:0] e1;
  } led_vec_t;

  led_vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_ce(input logic want);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (cpu_ce == want) found = 1;
      else tick();
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_ce: got no cpu_ce=%0b within 20 cycles want found", want);
    end
  endtask

  initial begin
    tbl[0] = '{wr: 2'b10, d0: 16'h0000, d1: 16'h1234, on_ce: 1'b0, e0: LEDR,     e1: LEDR};
    tbl[1] = '{wr: 2'b10, d0: 16'h0000, d1: 16'h1234, on_ce: 1'b1, e0: LEDR,     e1: 16'h1234};
    tbl[2] = '{wr: 2'b01, d0: 16'hBEEF, d1: 16'hFFFF, on_ce: 1'b1, e0: 16'hBEEF, e1: 16'h1234};
    tbl[3] = '{wr: 2'b11, d0: 16'h0F0F, d1: 16'hF0F0, on_ce: 1'b1, e0: 16'h0F0F, e1: 16'hF0F0};
    tbl[4] = '{wr: 2'b11, d0: 16'h1111, d1: 16'h2222, on_ce: 1'b0, e0: 16'h0F0F, e1: 16'hF0F0};
    tbl[5] = '{wr: 2'b00, d0: 16'h3333, d1: 16'h4444, on_ce: 1'b1, e0: 16'h0F0F, e1: 16'hF0F0};

    rst_n = 1'b0;
    sw_in = '0;
    cpu_wr_data = '0;
    cpu_wr_strobe = '0;
    cpu_rd_strobe = '0;
    tick();
    tick();
    check("reset_led", led_out, {LEDR, LEDR});
    check("reset_rd", cpu_rd_data, 32'h0);
    check("reset_sts", {16'h0, sts_data}, 32'h0);
    check("reset_ce", {31'h0, cpu_ce}, 32'h0);

    // cpu_ce high exactly in cycles 4, 8, 12 after release
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      tick();
      check($sformatf("ce_cycle%0d", cyc), {31'h0, cpu_ce}, {31'h0, (cyc % 4 == 0)});
    end
    check("post_reset_led", led_out, {LEDR, LEDR});
    check("post_reset_rd", cpu_rd_data, 32'h0);

    // clean step: 7 cycles to cpu_rd_data, sts one cycle later
    sw_in[15:0] = 16'hA5A5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) check("deb_rd_early", cpu_rd_data, 32'h0);
      if (k == 7) check("deb_rd_7", cpu_rd_data, 32'h0000_A5A5);
      if (k == 7) check("deb_sts_7", {16'h0, sts_data}, 32'h0);
      if (k == 8) check("deb_sts_8", {16'h0, sts_data}, 32'h1);
    end

    // 2-cycle glitch never gets through
    sw_in[15:0] = 16'hFFFF;
    tick();
    tick();
    sw_in[15:0] = 16'hA5A5;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("glitch_rd%0d", k), cpu_rd_data, 32'h0000_A5A5);
    end
    check("glitch_sts", {16'h0, sts_data}, 32'h1);

    wait_ce(1'b1);
    cpu_rd_strobe = 2'b01;
    tick();
    cpu_rd_strobe = 2'b00;
    tick();
    check("clear_sts", {16'h0, sts_data}, 32'h0);

    // LED write table
    for (int i = 0; i < 6; i++) begin
      wait_ce(tbl[i].on_ce);
      cpu_wr_strobe = tbl[i].wr;
      cpu_wr_data   = {tbl[i].d1, tbl[i].d0};
      tick();
      cpu_wr_strobe = 2'b00;
      check($sformatf("led_vec%0d", i), led_out, {tbl[i].e1, tbl[i].e0});
    end

    // flag race: stable load and qualified read clear on the same edge
    wait_ce(1'b1);
    tick();
    tick();
    sw_in[15:0] = 16'h0F0F;
    for (int k = 0; k < 6; k++) tick();
    check("race_ce", {31'h0, cpu_ce}, 32'h1);
    check("race_rd_before", cpu_rd_data, 32'h0000_A5A5);
    cpu_rd_strobe = 2'b01;
    tick();
    cpu_rd_strobe = 2'b00;
    check("race_rd_after", cpu_rd_data, 32'h0000_0F0F);
    tick();
    check("race_sts_set", {16'h0, sts_data}, 32'h1);
    wait_ce(1'b1);
    cpu_rd_strobe = 2'b01;
    tick();
    cpu_rd_strobe = 2'b00;
    tick();
    check("race_sts_clr", {16'h0, sts_data}, 32'h0);

    // channel 1 debounces and flags independently
    sw_in[31:16] = 16'h00C3;
    for (int k = 0; k < 8; k++) tick();
    check("ch1_rd", cpu_rd_data, 32'h00C3_0F0F);
    check("ch1_sts", {16'h0, sts_data}, 32'h2);

    // reset two cycles into a debounce window
    sw_in[15:0] = 16'h7E7E;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_led", led_out, {LEDR, LEDR});
    check("mid_rst_rd", cpu_rd_data, 32'h0);
    check("mid_rst_sts", {16'h0, sts_data}, 32'h0);
    check("mid_rst_ce", {31'h0, cpu_ce}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("rel_ce%0d", k), {31'h0, cpu_ce}, {31'h0, (k == 4)});
      if (k == 6) check("rel_rd_early", cpu_rd_data, 32'h0);
      if (k == 7) check("rel_rd_7", cpu_rd_data, 32'h00C3_7E7E);
    end
    tick();
    check("rel_sts", {16'h0, sts_data}, 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
